// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 UART transmitter.
//   A small TX FIFO takes CPU byte writes. A baud-rate serializer drains the
//   FIFO onto a registered serial line.
// Ports:
//   clk, reset            - system clock, async active-high reset
//   ip_data_addr[31:0]    - bit 31 device select, [3:2] register index
//   ip_data_wr            - write strobe
//   ip_data_mask[3:0]     - byte-lane enables (lane 0 only)
//   ip_data_from_proc     - write data
//   ip_data_rd            - read strobe
//   op_data_valid         - read data valid (combinational)
//   op_data_from_dev      - read data (combinational)
//   op_tx                 - serial output, idles high
// Register map: 0 TXDATA (wo), 1 STATUS {count[12:8], overflow[2], idle[1], ready[0]}
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ip_data_addr,
  input  logic        ip_data_wr,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_from_proc,
  input  logic        ip_data_rd,
  output logic        op_data_valid,
  output logic [31:0] op_data_from_dev,
  output logic        op_tx
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];

  logic            sel;
  logic [1:0]      reg_idx;
  logic            wr_txdata;
  logic            wr_status;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            tx_ready;
  logic            tx_idle;
  logic [31:0]     status;

  // Address decode and FIFO flags, judged on pre-edge state
  assign sel        = ip_data_addr[31];
  assign reg_idx    = ip_data_addr[3:2];
  assign wr_txdata  = ip_data_wr & sel & (reg_idx == REG_TXDATA) & ip_data_mask[0];
  assign wr_status  = ip_data_wr & sel & (reg_idx == REG_STATUS);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = wr_txdata & ~fifo_full;
  assign tx_ready   = (count_q < CW'(FIFO_DEPTH));
  assign tx_idle    = fifo_empty & (state_q == ST_IDLE);
  assign status     = {19'd0, 5'(count_q), 5'd0, ovf_q, tx_idle, tx_ready};

  // Bus read path
  assign op_data_valid    = ip_data_rd & sel;
  assign op_data_from_dev = (op_data_valid && (reg_idx == REG_STATUS)) ? status : 32'd0;
  assign op_tx            = tx_q;

  // Next-state: serializer, FIFO, overflow flag and line level
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    ovf_d     = ovf_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_d     = mem_q;
    pop       = 1'b0;
    tx_d      = 1'b1;

    // A full-FIFO write is dropped even if a pop frees a slot on the same edge
    if (wr_txdata && fifo_full) begin
      ovf_d = 1'b1;
    end else if (wr_status && ip_data_from_proc[2]) begin
      ovf_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = BW'(CLKS_PER_BIT - 1);
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          baud_d    = BW'(CLKS_PER_BIT - 1);
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d    = BW'(CLKS_PER_BIT - 1);
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          // Chain straight into the next frame when bytes are waiting
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            baud_d  = BW'(CLKS_PER_BIT - 1);
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = ip_data_from_proc[7:0];
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Line level follows the state being entered so op_tx stays registered
    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  // Address, lane and data bits the register map does not use
  logic unused_bits;
  assign unused_bits = ^{ip_data_addr[30:4], ip_data_addr[1:0],
                         ip_data_mask[3:1], ip_data_from_proc[31:8]};

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;

  logic        clk;
  logic        reset;
  logic [31:0] ip_data_addr;
  logic        ip_data_wr;
  logic [3:0]  ip_data_mask;
  logic [31:0] ip_data_from_proc;
  logic        ip_data_rd;
  logic        op_data_valid;
  logic [31:0] op_data_from_dev;
  logic        op_tx;

  int n_chk;
  int n_bad;
  int cyc;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .ip_data_addr      (ip_data_addr),
    .ip_data_wr        (ip_data_wr),
    .ip_data_mask      (ip_data_mask),
    .ip_data_from_proc (ip_data_from_proc),
    .ip_data_rd        (ip_data_rd),
    .op_data_valid     (op_data_valid),
    .op_data_from_dev  (op_data_from_dev),
    .op_tx             (op_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive a one-cycle write starting at a negedge; returns at the next negedge
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask);
    ip_data_addr      = addr;
    ip_data_from_proc = data;
    ip_data_mask      = mask;
    ip_data_wr        = 1'b1;
    @(negedge clk);
    ip_data_wr   = 1'b0;
    ip_data_mask = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic valid);
    ip_data_addr = addr;
    ip_data_rd   = 1'b1;
    #1;
    data  = op_data_from_dev;
    valid = op_data_valid;
    ip_data_rd = 1'b0;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    int slot;
    slot = i / int'(CPB);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  // Check n frames sample by sample; first sample is taken at the current negedge
  task automatic run_frames(input logic [7:0] b0, input logic [7:0] b1, input int n,
                            output int peak);
    logic [31:0] st;
    logic        v;
    logic [7:0]  cur;
    peak = 0;
    for (int i = 0; i < n * 10 * int'(CPB); i++) begin
      if (i > 0) @(negedge clk);
      cur = (i < 10 * int'(CPB)) ? b0 : b1;
      chk("tx_bit", 32'(op_tx), 32'(exp_bit(cur, i % (10 * int'(CPB)))));
      bus_read(A_ST, st, v);
      if (int'(st[12:8]) > peak) peak = int'(st[12:8]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st;
    logic        v;
    int          peak;
    int          t0;
    bit          seen;
    bit          all_high;

    n_chk = 0;
    n_bad = 0;
    cyc   = 0;
    reset = 1'b0;
    ip_data_addr      = '0;
    ip_data_wr        = 1'b0;
    ip_data_mask      = '0;
    ip_data_from_proc = '0;
    ip_data_rd        = 1'b0;

    // Reset asserted between edges
    #3 reset = 1'b1;
    #1 chk("rst_tx", 32'(op_tx), 32'd1);
    bus_read(A_ST, st, v);
    chk("rst_valid", 32'(v), 32'd1);
    chk("rst_status", st, 32'h3);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single byte 0x55
    bus_write(A_TX, 32'h55, 4'hF);
    chk("lat_hold", 32'(op_tx), 32'd1);
    @(negedge clk);
    run_frames(8'h55, 8'h00, 1, peak);
    @(negedge clk);
    bus_read(A_ST, st, v);
    chk("single_status", st, 32'h3);

    // Back-to-back 0xA5, 0x0F
    bus_write(A_TX, 32'hA5, 4'hF);
    bus_write(A_TX, 32'h0F, 4'hF);
    run_frames(8'hA5, 8'h0F, 2, peak);
    chk("b2b_peak", 32'(peak), 32'd1);
    @(negedge clk);
    bus_read(A_ST, st, v);
    chk("b2b_status", st, 32'h3);

    // Overflow: six writes in six cycles
    t0 = 0;
    for (int i = 0; i < 6; i++) begin
      bus_write(A_TX, 32'h11 + 32'(i), 4'hF);
      if (i == 0) t0 = cyc;
    end
    bus_read(A_ST, st, v);
    chk("ovf_status", st, 32'h0000_0404);
    bus_write(A_ST, 32'h0, 4'hF);
    bus_read(A_ST, st, v);
    chk("ovf_keep", st, 32'h0000_0404);
    // Clear overflow while reading STATUS in the same cycle
    ip_data_addr      = A_ST;
    ip_data_from_proc = 32'h4;
    ip_data_mask      = 4'hF;
    ip_data_wr        = 1'b1;
    ip_data_rd        = 1'b1;
    #1 chk("rd_during_clr", op_data_from_dev, 32'h0000_0404);
    @(negedge clk);
    ip_data_wr   = 1'b0;
    ip_data_rd   = 1'b0;
    ip_data_mask = 4'h0;
    bus_read(A_ST, st, v);
    chk("ovf_cleared", st, 32'h0000_0400);
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      bus_read(A_ST, st, v);
      if (st[1]) seen = 1'b1;
      else @(negedge clk);
    end
    chk("drain_idle_seen", 32'(seen), 32'd1);
    chk("drain_cycles", 32'(cyc - t0), 32'd201);
    chk("drain_status", st, 32'h3);

    // Mask and select
    bus_write(A_TX, 32'h5A, 4'b1110);
    @(negedge clk);
    @(negedge clk);
    bus_read(A_ST, st, v);
    chk("mask_status", st, 32'h3);
    chk("mask_tx", 32'(op_tx), 32'd1);
    bus_write(32'h0000_0000, 32'h00, 4'hF);
    all_high = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (op_tx !== 1'b1) all_high = 1'b0;
      @(negedge clk);
    end
    chk("nosel_tx_high", 32'(all_high), 32'd1);
    bus_read(A_ST, st, v);
    chk("nosel_status", st, 32'h3);
    bus_read(32'h0000_0004, st, v);
    chk("nosel_rd_valid", 32'(v), 32'd0);
    chk("nosel_rd_data", st, 32'h0);
    bus_read(32'h8000_0008, st, v);
    chk("rsvd_rd_valid", 32'(v), 32'd1);
    chk("rsvd_rd_data", st, 32'h0);
    bus_read(A_TX, st, v);
    chk("txdata_rd_data", st, 32'h0);

    // Reset during DATA bit 3 with two bytes queued
    bus_write(A_TX, 32'h11, 4'hF);
    bus_write(A_TX, 32'h22, 4'hF);
    bus_write(A_TX, 32'h33, 4'hF);
    repeat (16) @(negedge clk);
    bus_read(A_ST, st, v);
    chk("mid_status", st, 32'h0000_0201);
    chk("mid_tx_low", 32'(op_tx), 32'd0);
    #2 reset = 1'b1;
    #1 chk("mid_rst_tx", 32'(op_tx), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    all_high = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (op_tx !== 1'b1) all_high = 1'b0;
    end
    chk("post_rst_quiet", 32'(all_high), 32'd1);
    bus_read(A_ST, st, v);
    chk("post_rst_status", st, 32'h3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
